// File: rtl/sync_fifo_lvl_pkg.sv
// Shared FIFO mode constants for sync_fifo_lvl and the peripherals that instantiate it.
//   FIFO_MODE_FWFT : head word visible on rdata_o while the FIFO is non-empty
//   FIFO_MODE_REG  : registered read, data appears one cycle after the pop
package sync_fifo_lvl_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

endpackage

// File: rtl/sync_fifo_lvl_fifo_mem.sv
// fifo_mem: WIDTH x DEPTH storage array, one synchronous write port and one
// asynchronous read port. No reset on the array.
//   clk_i    : clock
//   we_i     : write enable (already qualified by the FIFO control)
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, combinational from raddr_i
module fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: synchronous FIFO with occupancy level, almost-full/almost-empty
// thresholds, flush, sticky overflow/underflow and selectable read mode.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   flush_i                : discard contents (pointers to zero)
//   err_clr_i              : clear sticky overflow_o/underflow_o
//   we_i, wdata_i          : write request and data
//   re_i                   : read request (pop)
//   rdata_o, rvalid_o      : read data and valid
//   full_o, empty_o        : level == DEPTH / level == 0
//   level_o                : occupied entries 0..DEPTH
//   afull_thr_i, afull_o   : afull_o = level_o >= afull_thr_i
//   aempty_thr_i, aempty_o : aempty_o = level_o <= aempty_thr_i
//   overflow_o, underflow_o: sticky error flags
module sync_fifo_lvl
  import sync_fifo_lvl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int FWFT  = FIFO_MODE_FWFT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             err_clr_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rvalid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o,
  input  logic [AW:0]      afull_thr_i,
  input  logic [AW:0]      aempty_thr_i,
  output logic             afull_o,
  output logic             aempty_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      w_ptr_q, w_ptr_d;
  logic [AW:0]      r_ptr_q, r_ptr_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic             wr_acc, rd_acc;
  logic             ovf_set, unf_set;
  logic [WIDTH-1:0] mem_rdata;

  // Status comes only from the registered pointers; the MSB is the wrap bit.
  assign level_o = w_ptr_q - r_ptr_q;
  assign empty_o = (w_ptr_q == r_ptr_q);
  assign full_o  = (w_ptr_q[AW-1:0] == r_ptr_q[AW-1:0]) && (w_ptr_q[AW] != r_ptr_q[AW]);

  // Threshold wider than DEPTH can never be reached, so afull_o stays low.
  assign afull_o  = (level_o >= afull_thr_i);
  assign aempty_o = (level_o <= aempty_thr_i);

  assign wr_acc  = we_i & ~full_o  & ~flush_i;
  assign rd_acc  = re_i & ~empty_o & ~flush_i;
  assign ovf_set = we_i & full_o  & ~flush_i;
  assign unf_set = re_i & empty_o & ~flush_i;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_acc),
    .waddr_i (w_ptr_q[AW-1:0]),
    .wdata_i (wdata_i),
    .raddr_i (r_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    w_ptr_d  = w_ptr_q;
    r_ptr_d  = r_ptr_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    // A set in the same cycle as a clear wins.
    ovf_d    = (ovf_q & ~err_clr_i) | ovf_set;
    unf_d    = (unf_q & ~err_clr_i) | unf_set;

    if (flush_i) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
    end else begin
      if (wr_acc) begin
        w_ptr_d = w_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
        r_ptr_d  = r_ptr_q + PTR_ONE;
        rdata_d  = mem_rdata;
        rvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_ptr_q  <= '0;
      r_ptr_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      w_ptr_q  <= w_ptr_d;
      r_ptr_q  <= r_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

  // In first-word-fall-through mode the read register is bypassed entirely.
  assign rdata_o  = (FWFT == FIFO_MODE_FWFT) ? (empty_o ? '0 : mem_rdata) : rdata_q;
  assign rvalid_o = (FWFT == FIFO_MODE_FWFT) ? ~empty_o : rvalid_q;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
module tb_sync_fifo_lvl;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n, flush, clr, we, re;
  logic [W-1:0] wdata;
  logic [2:0]   athr, ethr;

  logic [W-1:0] f_rdata, r_rdata;
  logic         f_rvalid, r_rvalid, f_full, r_full, f_empty, r_empty;
  logic [2:0]   f_level, r_level;
  logic         f_afull, r_afull, f_aempty, r_aempty, f_ovf, r_ovf, f_unf, r_unf;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of words plus flags and the registered-read state.
  logic [W-1:0] q[$];
  bit           m_ovf, m_unf;
  logic [W-1:0] m_rdata_r;
  bit           m_rvalid_r;

  always #5 clk = ~clk;

  sync_fifo_lvl #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .err_clr_i(clr),
    .we_i(we), .wdata_i(wdata), .re_i(re),
    .rdata_o(f_rdata), .rvalid_o(f_rvalid), .full_o(f_full), .empty_o(f_empty),
    .level_o(f_level), .afull_thr_i(athr), .aempty_thr_i(ethr),
    .afull_o(f_afull), .aempty_o(f_aempty), .overflow_o(f_ovf), .underflow_o(f_unf)
  );

  sync_fifo_lvl #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_reg (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .err_clr_i(clr),
    .we_i(we), .wdata_i(wdata), .re_i(re),
    .rdata_o(r_rdata), .rvalid_o(r_rvalid), .full_o(r_full), .empty_o(r_empty),
    .level_o(r_level), .afull_thr_i(athr), .aempty_thr_i(ethr),
    .afull_o(r_afull), .aempty_o(r_aempty), .overflow_o(r_ovf), .underflow_o(r_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    int           lvl;
    logic [W-1:0] head;
    lvl  = q.size();
    head = (lvl == 0) ? '0 : q[0];
    chk("f_level", f_level, lvl);
    chk("r_level", r_level, lvl);
    chk("f_full", f_full, lvl == D);
    chk("r_full", r_full, lvl == D);
    chk("f_empty", f_empty, lvl == 0);
    chk("r_empty", r_empty, lvl == 0);
    chk("f_afull", f_afull, lvl >= int'(athr));
    chk("r_afull", r_afull, lvl >= int'(athr));
    chk("f_aempty", f_aempty, lvl <= int'(ethr));
    chk("r_aempty", r_aempty, lvl <= int'(ethr));
    chk("f_ovf", f_ovf, m_ovf);
    chk("r_ovf", r_ovf, m_ovf);
    chk("f_unf", f_unf, m_unf);
    chk("r_unf", r_unf, m_unf);
    chk("f_rdata", f_rdata, head);
    chk("f_rvalid", f_rvalid, lvl != 0);
    chk("r_rdata", r_rdata, m_rdata_r);
    chk("r_rvalid", r_rvalid, m_rvalid_r);
  endtask

  task automatic model_edge(input bit w, input logic [W-1:0] d, input bit r,
                            input bit fl, input bit cl);
    bit full_now, empty_now, ovs, uns;
    full_now  = (q.size() == D);
    empty_now = (q.size() == 0);
    ovs = 1'b0;
    uns = 1'b0;
    if (fl) begin
      q.delete();
      m_rvalid_r = 1'b0;
    end else begin
      ovs = w && full_now;
      uns = r && empty_now;
      if (r && !empty_now) begin
        m_rdata_r  = q.pop_front();
        m_rvalid_r = 1'b1;
      end else begin
        m_rvalid_r = 1'b0;
      end
      if (w && !full_now) q.push_back(d);
    end
    m_ovf = (m_ovf && !cl) || ovs;
    m_unf = (m_unf && !cl) || uns;
  endtask

  // Called just after a rising edge: drive, check current state, clock, update model.
  task automatic step(input bit w, input logic [W-1:0] d, input bit r,
                      input bit fl = 1'b0, input bit cl = 1'b0);
    we = w; wdata = d; re = r; flush = fl; clr = cl;
    #1;
    check_state();
    @(posedge clk);
    #1;
    model_edge(w, d, r, fl, cl);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; we = 0; re = 0; flush = 0; clr = 0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    m_ovf = 0; m_unf = 0; m_rdata_r = '0; m_rvalid_r = 0;
  endtask

  initial begin
    athr = 3'd4; ethr = 3'd0;
    do_reset();

    // 1: fill to full then drain in order
    step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0); step(1, 8'h44, 0);
    step(1, 8'h99, 0);                       // write while full -> overflow
    step(0, 0, 1, 0, 1);                     // pop + clear
    step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
    step(0, 0, 0);

    // 2: full, simultaneous write+read
    step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0); step(1, 8'h44, 0);
    step(1, 8'h55, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0);

    // 3: empty, simultaneous write+read
    step(0, 0, 1, 1);
    step(1, 8'h66, 1);
    step(0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0);

    // 4: thresholds afull=3 aempty=1 across levels 0..4
    athr = 3'd3; ethr = 3'd1;
    step(0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 8'(8'hA0 + i), 0);
    step(0, 0, 0);
    athr = 3'd5;                              // above DEPTH: never almost-full
    step(0, 0, 0);

    // 5: flush at level 3 with a write pending
    step(0, 0, 1, 0, 1);
    step(1, 8'h77, 0, 1);
    step(0, 0, 0);

    // 6: interleaved write/pop pairs across pointer wrap
    athr = 3'd3;
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(i), 0);
      step(0, 0, 1);
    end
    step(0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        athr = 3'($urandom_range(0, 7));
        ethr = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)),
             $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
      end
    end
    we = 0; re = 0; flush = 0; clr = 0;
    #1;
    check_state();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
